// File: rtl/compare_sweep_ctrl_if.sv
// Purpose : operand/flag bus between the sweep controller and a 2-bit comparator under test.
// Latency : none, plain wires.
// Backpr. : none, flags are sampled only after the operands have settled.
// Ports   : A, B    - operands, driven by the controller (master)
//           AgtB, AeqB, AltB - comparator flags, driven by the comparator (slave)
interface compare_sweep_ctrl_if;
  logic [1:0] A;
  logic [1:0] B;
  logic       AgtB;
  logic       AeqB;
  logic       AltB;

  modport master (
    output A,
    output B,
    input  AgtB,
    input  AeqB,
    input  AltB
  );

  modport slave (
    input  A,
    input  B,
    output AgtB,
    output AeqB,
    output AltB
  );
endinterface

// File: rtl/compare_sweep_ctrl.sv
// Purpose : sweeps all 16 {A,B} operand pairs into a 2-bit comparator and checks its one-hot flags.
// Latency : done pulses 16*(SETTLE_CYCLES+1) cycles after the start-accepting edge.
// Backpr. : none; start is only honoured in IDLE, abort cancels a running sweep at the next edge.
// Ports   : clk, rst_n (async, active-low); start/abort control inputs;
//           cmp (master) drives A/B and receives AgtB/AeqB/AltB;
//           busy, done, pass, err_cnt, first_fail_idx, first_fail_valid status outputs.
module compare_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  compare_sweep_ctrl_if.master        cmp,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [4:0]                  err_cnt,
  output logic [3:0]                  first_fail_idx,
  output logic                        first_fail_valid
);

  // The settle counter is 4 bits wide, so anything outside 1..15 cannot be represented.
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("compare_sweep_ctrl: SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [3:0] IDX_LAST    = 4'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] settle_q, settle_d;
  logic [4:0] err_cnt_q, err_cnt_d;
  logic [3:0] ff_idx_q, ff_idx_d;
  logic       ff_vld_q, ff_vld_d;
  logic       pass_q, pass_d;

  // Flag evaluation against the registered operands.
  logic [1:0] op_a;
  logic [1:0] op_b;
  logic [2:0] flags_exp;
  logic [2:0] flags_obs;
  logic       mismatch;
  logic [4:0] err_cnt_inc;

  always_comb begin
    op_a      = idx_q[3:2];
    op_b      = idx_q[1:0];
    flags_exp = {(op_a > op_b), (op_a == op_b), (op_a < op_b)};
    flags_obs = {cmp.AgtB, cmp.AeqB, cmp.AltB};
    // A whole-vector compare catches all-zero and multi-hot flags as well as a wrong single flag.
    mismatch    = (flags_obs != flags_exp);
    err_cnt_inc = err_cnt_q + {4'd0, mismatch};
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    err_cnt_d = err_cnt_q;
    ff_idx_d = ff_idx_q;
    ff_vld_d = ff_vld_q;
    pass_d   = pass_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = WAIT;
          idx_d     = 4'd0;
          settle_d  = SETTLE_LOAD;
          err_cnt_d = 5'd0;
          ff_idx_d  = 4'd0;
          ff_vld_d  = 1'b0;
          pass_d    = 1'b0;
        end
      end

      WAIT: begin
        if (abort) begin
          // Operands return to zero so the comparator sees a quiet bus after a cancel.
          state_d = IDLE;
          idx_d   = 4'd0;
        end else begin
          settle_d = settle_q - 4'd1;
          // <= rather than == so a corrupted zero count cannot wrap into a 16-cycle stall.
          if (settle_q <= 4'd1) begin
            state_d = SAMPLE;
          end
        end
      end

      SAMPLE: begin
        if (abort) begin
          // Abort wins: the vector under test is dropped without being scored.
          state_d = IDLE;
          idx_d   = 4'd0;
        end else begin
          if (mismatch) begin
            err_cnt_d = err_cnt_inc;
            if (!ff_vld_q) begin
              ff_idx_d = idx_q;
              ff_vld_d = 1'b1;
            end
          end
          if (idx_q == IDX_LAST) begin
            // pass must already be valid during the DONE cycle, so use the count including this vector.
            state_d = DONE;
            pass_d  = (err_cnt_inc == 5'd0);
          end else begin
            state_d  = WAIT;
            idx_d    = idx_q + 4'd1;
            settle_d = SETTLE_LOAD;
          end
        end
      end

      DONE: begin
        // Unconditional return; a held start is picked up on the following IDLE edge.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      settle_q  <= 4'd0;
      err_cnt_q <= 5'd0;
      ff_idx_q  <= 4'd0;
      ff_vld_q  <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      settle_q  <= settle_d;
      err_cnt_q <= err_cnt_d;
      ff_idx_q  <= ff_idx_d;
      ff_vld_q  <= ff_vld_d;
      pass_q    <= pass_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded straight from flops, so reset clears them without a clock.
  // ---------------------------------------------------------------------------
  assign cmp.A            = idx_q[3:2];
  assign cmp.B            = idx_q[1:0];
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);
  assign pass             = pass_q;
  assign err_cnt          = err_cnt_q;
  assign first_fail_idx   = ff_idx_q;
  assign first_fail_valid = ff_vld_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_err_range : assert property (@(posedge clk) disable iff (!rst_n) err_cnt_q <= 5'd16);
  a_done_1cyc : assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
  a_ff_vld    : assert property (@(posedge clk) disable iff (!rst_n)
                                 (err_cnt_q != 5'd0) == ff_vld_q);

endmodule

// File: tb/tb_compare_sweep_ctrl.sv
module tb_compare_sweep_ctrl;

  localparam int SETTLE = 1;
  localparam int LAT    = 16 * (SETTLE + 1);

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_cnt;
  logic [3:0] first_fail_idx;
  logic       first_fail_valid;

  int n_chk;
  int n_pass;

  // Comparator stub with injectable faults.
  logic        stuck_eq;
  logic [15:0] bad_mask;

  compare_sweep_ctrl_if cmp ();

  assign cmp.AgtB = bad_mask[{cmp.A, cmp.B}] ? 1'b1 : (cmp.A > cmp.B);
  assign cmp.AeqB = bad_mask[{cmp.A, cmp.B}] ? 1'b1 : ((cmp.A == cmp.B) && !stuck_eq);
  assign cmp.AltB = bad_mask[{cmp.A, cmp.B}] ? 1'b1 : (cmp.A < cmp.B);

  compare_sweep_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .cmp              (cmp.master),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_cnt          (err_cnt),
    .first_fail_idx   (first_fail_idx),
    .first_fail_valid (first_fail_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] err;
    logic [3:0] ff_idx;
    logic       ff_vld;
    logic       pass;
    int         lat;
  } exp_t;

  exp_t sb_q[$];

  // Independent sweep model: derives the expected result for the current fault settings.
  function automatic void push_expect();
    exp_t       e;
    int         a;
    int         b;
    logic [2:0] want;
    logic [2:0] got;
    e.err    = 5'd0;
    e.ff_idx = 4'd0;
    e.ff_vld = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a    = i / 4;
      b    = i % 4;
      want = {(a > b), (a == b), (a < b)};
      got  = want;
      if (stuck_eq) got[1] = 1'b0;
      if (bad_mask[i]) got = 3'b111;
      if (got != want) begin
        if (!e.ff_vld) begin
          e.ff_idx = 4'(i);
          e.ff_vld = 1'b1;
        end
        e.err = e.err + 5'd1;
      end
    end
    e.pass = (e.err == 5'd0);
    e.lat  = LAT;
    sb_q.push_back(e);
  endfunction

  // Runs one sweep, checking the operand sequence every cycle, then pops and checks the result.
  // When started=1 the caller has just passed the start-accepting edge.
  task automatic run_sweep(input bit started, input bit hold, input string name);
    exp_t e;
    int   done_k;
    if (!started) begin
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
    end
    done_k = -1;
    for (int k = 0; k <= LAT + 4 && done_k < 0; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (k == 0) begin
        n_chk++;
        if (err_cnt !== 5'd0 || first_fail_valid !== 1'b0 || pass !== 1'b0)
          $display("FAIL %s clear_on_start err_cnt=%0d ffv=%b pass=%b want 0/0/0",
                   name, err_cnt, first_fail_valid, pass);
        else n_pass++;
      end
      if (k < LAT) begin
        n_chk++;
        if ({cmp.A, cmp.B} !== 4'(k / (SETTLE + 1)) || busy !== 1'b1 || done !== 1'b0)
          $display("FAIL %s vector k=%0d AB=%h busy=%b done=%b want AB=%h busy=1 done=0",
                   name, k, {cmp.A, cmp.B}, busy, done, 4'(k / (SETTLE + 1)));
        else n_pass++;
      end
      if (done === 1'b1) done_k = k;
    end
    n_chk++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s scoreboard empty", name);
    end else begin
      n_pass++;
      e = sb_q.pop_front();
      n_chk++;
      if (done_k != e.lat) $display("FAIL %s latency got=%0d want=%0d", name, done_k, e.lat);
      else n_pass++;
      n_chk++;
      if (err_cnt !== e.err || pass !== e.pass)
        $display("FAIL %s result err_cnt=%0d pass=%b want err_cnt=%0d pass=%b",
                 name, err_cnt, pass, e.err, e.pass);
      else n_pass++;
      n_chk++;
      if (first_fail_valid !== e.ff_vld || first_fail_idx !== e.ff_idx)
        $display("FAIL %s first_fail vld=%b idx=%0d want vld=%b idx=%0d",
                 name, first_fail_valid, first_fail_idx, e.ff_vld, e.ff_idx);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    stuck_eq = 1'b0;
    bad_mask = 16'd0;
    #12;
    n_chk++;
    if ({busy, done, pass, err_cnt, first_fail_idx, first_fail_valid, cmp.A, cmp.B} !== 17'd0)
      $display("FAIL reset_state busy=%b done=%b pass=%b err=%0d ffi=%0d ffv=%b A=%0d B=%0d want all 0",
               busy, done, pass, err_cnt, first_fail_idx, first_fail_valid, cmp.A, cmp.B);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL idle_after_reset busy=%b done=%b want 0/0", busy, done);
    else n_pass++;
  endtask

  task automatic test_golden();
    stuck_eq = 1'b0;
    bad_mask = 16'd0;
    push_expect();
    run_sweep(1'b0, 1'b0, "golden");
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b1)
      $display("FAIL golden_after_done done=%b busy=%b pass=%b want 0/0/1", done, busy, pass);
    else n_pass++;
  endtask

  task automatic test_stuck_eq();
    stuck_eq = 1'b1;
    bad_mask = 16'd0;
    push_expect();
    n_chk++;
    if (sb_q[0].err !== 5'd4 || sb_q[0].ff_idx !== 4'd0) $display("FAIL stuck_eq_model err=%0d ffi=%0d want 4/0", sb_q[0].err, sb_q[0].ff_idx);
    else n_pass++;
    run_sweep(1'b0, 1'b0, "stuck_eq");
    stuck_eq = 1'b0;
  endtask

  task automatic test_idx5_multihot();
    bad_mask = 16'h0020;
    push_expect();
    run_sweep(1'b0, 1'b0, "idx5_multihot");
    bad_mask = 16'd0;
  endtask

  task automatic test_back_to_back();
    stuck_eq = 1'b1;
    push_expect();
    run_sweep(1'b0, 1'b1, "hold_first");
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || err_cnt !== 5'd4 || pass !== 1'b0)
      $display("FAIL hold_idle_gap busy=%b done=%b err=%0d pass=%b want 0/0/4/0", busy, done, err_cnt, pass);
    else n_pass++;
    stuck_eq = 1'b0;
    push_expect();
    @(posedge clk);
    run_sweep(1'b1, 1'b0, "hold_second");
  endtask

  task automatic test_abort();
    int seen_done;
    bad_mask  = 16'h00A0;
    seen_done = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) seen_done++;
    end
    // cycle 15 is the SAMPLE cycle of vector 7
    n_chk++;
    if ({cmp.A, cmp.B} !== 4'd7 || busy !== 1'b1)
      $display("FAIL abort_setup AB=%0d busy=%b want 7/1", {cmp.A, cmp.B}, busy);
    else n_pass++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || cmp.A !== 2'd0 || cmp.B !== 2'd0)
      $display("FAIL abort_idle busy=%b done=%b A=%0d B=%0d want 0/0/0/0", busy, done, cmp.A, cmp.B);
    else n_pass++;
    n_chk++;
    if (err_cnt !== 5'd1 || first_fail_idx !== 4'd5 || first_fail_valid !== 1'b1 || pass !== 1'b0)
      $display("FAIL abort_hold err=%0d ffi=%0d ffv=%b pass=%b want 1/5/1/0",
               err_cnt, first_fail_idx, first_fail_valid, pass);
    else n_pass++;
    abort = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    abort = 1'b0;
    n_chk++;
    if (seen_done != 0 || err_cnt !== 5'd1)
      $display("FAIL abort_no_done stray_cycles=%0d err=%0d want 0/1", seen_done, err_cnt);
    else n_pass++;
    bad_mask = 16'd0;
  endtask

  task automatic test_reset_mid();
    stuck_eq = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    n_chk++;
    if (busy !== 1'b1 || err_cnt !== 5'd1 || first_fail_valid !== 1'b1)
      $display("FAIL reset_mid_setup busy=%b err=%0d ffv=%b want 1/1/1", busy, err_cnt, first_fail_valid);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, pass, err_cnt, first_fail_idx, first_fail_valid, cmp.A, cmp.B} !== 17'd0)
      $display("FAIL reset_mid busy=%b done=%b pass=%b err=%0d ffi=%0d ffv=%b A=%0d B=%0d want all 0",
               busy, done, pass, err_cnt, first_fail_idx, first_fail_valid, cmp.A, cmp.B);
    else n_pass++;
    @(negedge clk);
    rst_n    = 1'b1;
    stuck_eq = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) $display("FAIL reset_mid_stay_idle busy=%b want 0", busy);
    else n_pass++;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_golden();
    test_stuck_eq();
    test_idx5_multihot();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    n_chk++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_leftover entries=%0d want 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

endmodule
